// File: rtl/laser_chip_interface.sv
// Board wrapper for a 4-lane nibble-serial laser link: frame transmitter on GPIO_1,
// frame receiver/validator on GPIO_0, status on LEDs and 7-segment displays.
module laser_chip_interface #(
  parameter int CLKS_PER_SYMBOL = 4,
  parameter int GAP_SYMBOLS     = 4
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [9:0] SW,
  input  logic [3:0] KEY,
  output logic       GPIO_1_D14,
  output logic       GPIO_1_D15,
  output logic       GPIO_1_D16,
  output logic       GPIO_1_D17,
  input  logic       GPIO_0_D14,
  input  logic       GPIO_0_D15,
  input  logic       GPIO_0_D16,
  input  logic       GPIO_0_D17,
  output logic [17:0] LEDR,
  output logic [6:0] HEX5,
  output logic [6:0] HEX4,
  output logic [6:0] HEX1,
  output logic [6:0] HEX0
);

  localparam logic [3:0] START_SYM = 4'hA;

  localparam logic [2:0] TX_IDLE  = 3'd0;
  localparam logic [2:0] TX_START = 3'd1;
  localparam logic [2:0] TX_HI    = 3'd2;
  localparam logic [2:0] TX_LO    = 3'd3;
  localparam logic [2:0] TX_CHK   = 3'd4;
  localparam logic [2:0] TX_GAP   = 3'd5;

  localparam logic [0:0] RX_HUNT  = 1'b0;
  localparam logic [0:0] RX_FRAME = 1'b1;

  localparam logic [15:0] SYM_LAST = 16'(CLKS_PER_SYMBOL - 1);
  // The single IDLE cycle before the next START completes the gap, so GAP stops one short.
  localparam logic [15:0] GAP_LAST = 16'(GAP_SYMBOLS * CLKS_PER_SYMBOL - 2);
  localparam logic [15:0] HI_MID   = 16'(CLKS_PER_SYMBOL + CLKS_PER_SYMBOL / 2);
  localparam logic [15:0] LO_MID   = 16'(2 * CLKS_PER_SYMBOL + CLKS_PER_SYMBOL / 2);
  localparam logic [15:0] CHK_MID  = 16'(3 * CLKS_PER_SYMBOL + CLKS_PER_SYMBOL / 2);

  logic        unused_keys;
  assign unused_keys = ^{KEY[3:2], KEY[0]};

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // Single-shot button: synchronize, then detect the press (falling) edge.
  logic key_s1, key_s2, key_prev;
  logic key_fall;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      key_s1   <= 1'b1;
      key_s2   <= 1'b1;
      key_prev <= 1'b1;
    end else begin
      key_s1   <= KEY[1];
      key_s2   <= key_s1;
      key_prev <= key_s2;
    end
  end

  assign key_fall = key_prev & ~key_s2;

  logic [2:0]  tx_state;
  logic [15:0] tx_cnt;
  logic [3:0]  tx_sym;
  logic [7:0]  payload;
  logic        inject;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= 16'd0;
      tx_sym   <= 4'h0;
      payload  <= 8'h00;
      inject   <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (SW[0] || key_fall) begin
            payload  <= SW[8:1];
            inject   <= SW[9];
            tx_sym   <= START_SYM;
            tx_cnt   <= 16'd0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == SYM_LAST) begin
            tx_cnt   <= 16'd0;
            tx_sym   <= payload[7:4];
            tx_state <= TX_HI;
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        TX_HI: begin
          if (tx_cnt == SYM_LAST) begin
            tx_cnt   <= 16'd0;
            tx_sym   <= payload[3:0];
            tx_state <= TX_LO;
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        TX_LO: begin
          if (tx_cnt == SYM_LAST) begin
            tx_cnt   <= 16'd0;
            tx_sym   <= payload[7:4] ^ payload[3:0] ^ {4{inject}};
            tx_state <= TX_CHK;
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        TX_CHK: begin
          if (tx_cnt == SYM_LAST) begin
            tx_cnt   <= 16'd0;
            tx_sym   <= 4'h0;
            tx_state <= TX_GAP;
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        TX_GAP: begin
          if (tx_cnt == GAP_LAST) begin
            tx_cnt   <= 16'd0;
            tx_state <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  assign {GPIO_1_D17, GPIO_1_D16, GPIO_1_D15, GPIO_1_D14} = tx_sym;

  logic [3:0]  rx_s1, rx_sync, rx_prev;
  logic [0:0]  rx_state;
  logic [15:0] rx_cnt;
  logic [3:0]  rx_hi, rx_lo;
  logic [7:0]  rx_byte;
  logic [7:0]  good_cnt;
  logic        data_valid;
  logic        chk_err;
  logic        frame_seen;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      rx_s1   <= 4'h0;
      rx_sync <= 4'h0;
      rx_prev <= 4'h0;
    end else begin
      rx_s1   <= {GPIO_0_D17, GPIO_0_D16, GPIO_0_D15, GPIO_0_D14};
      rx_sync <= rx_s1;
      rx_prev <= rx_sync;
    end
  end

  // rx_cnt holds the symbol-cycle offset from the START edge, so mid-symbol
  // samples land at fixed offsets regardless of line activity inside the frame.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      rx_state   <= RX_HUNT;
      rx_cnt     <= 16'd0;
      rx_hi      <= 4'h0;
      rx_lo      <= 4'h0;
      rx_byte    <= 8'h00;
      good_cnt   <= 8'h00;
      data_valid <= 1'b0;
      chk_err    <= 1'b0;
      frame_seen <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (rx_state)
        RX_HUNT: begin
          if (rx_prev == 4'h0 && rx_sync == START_SYM) begin
            rx_cnt   <= 16'd1;
            rx_state <= RX_FRAME;
          end
        end
        default: begin
          rx_cnt <= rx_cnt + 16'd1;
          if (rx_cnt == HI_MID) rx_hi <= rx_sync;
          if (rx_cnt == LO_MID) rx_lo <= rx_sync;
          if (rx_cnt == CHK_MID) begin
            rx_state <= RX_HUNT;
            if ((rx_hi ^ rx_lo) == rx_sync) begin
              rx_byte    <= {rx_hi, rx_lo};
              data_valid <= 1'b1;
              good_cnt   <= good_cnt + 8'd1;
              frame_seen <= 1'b1;
            end else begin
              chk_err <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign LEDR = {frame_seen, chk_err, good_cnt, rx_byte};
  assign HEX1 = hex7(rx_byte[7:4]);
  assign HEX0 = hex7(rx_byte[3:0]);
  assign HEX5 = hex7(payload[7:4]);
  assign HEX4 = hex7(payload[3:0]);

endmodule

// File: tb/tb_laser_chip_interface.sv
// Directed loopback bench for laser_chip_interface: TX lanes looped to RX lanes,
// with an optional override to drive malformed RX frames directly.
module tb_laser_chip_interface;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  sw;
  logic [3:0]  key;
  logic        g1_14, g1_15, g1_16, g1_17;
  logic        g0_14, g0_15, g0_16, g0_17;
  logic [17:0] ledr;
  logic [6:0]  hex5, hex4, hex1, hex0;

  logic [3:0]  tx_sym;
  logic [3:0]  rx_lanes;
  logic        rx_force;
  logic [3:0]  rx_alt;

  always #5 clk = ~clk;

  assign tx_sym   = {g1_17, g1_16, g1_15, g1_14};
  assign rx_lanes = rx_force ? rx_alt : tx_sym;
  assign {g0_17, g0_16, g0_15, g0_14} = rx_lanes;

  laser_chip_interface dut (
    .CLOCK_50  (clk),
    .reset     (rst),
    .SW        (sw),
    .KEY       (key),
    .GPIO_1_D14(g1_14),
    .GPIO_1_D15(g1_15),
    .GPIO_1_D16(g1_16),
    .GPIO_1_D17(g1_17),
    .GPIO_0_D14(g0_14),
    .GPIO_0_D15(g0_15),
    .GPIO_0_D16(g0_16),
    .GPIO_0_D17(g0_17),
    .LEDR      (ledr),
    .HEX5      (hex5),
    .HEX4      (hex4),
    .HEX1      (hex1),
    .HEX0      (hex0)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Event monitors on the falling edge: data_valid pulses, pulse width, TX frame starts.
  int       dv_cnt = 0;
  int       dv_long = 0;
  int       start_cnt = 0;
  logic     dv_prev = 1'b0;
  logic [3:0] tx_prev = 4'h0;

  always @(negedge clk) begin
    if (dut.data_valid) begin
      dv_cnt++;
      if (dv_prev) dv_long++;
    end
    dv_prev = dut.data_valid;
    if (tx_prev == 4'h0 && tx_sym == 4'hA) start_cnt++;
    tx_prev = tx_sym;
  end

  int last_wait;

  task automatic wait_dv(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (dv_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    last_wait = n;
    if (dv_cnt < target) check({tag, "_timeout"}, dv_cnt, target);
  endtask

  task automatic do_reset(input logic [9:0] s);
    rst      = 1'b1;
    sw       = s;
    key      = 4'hF;
    rx_force = 1'b0;
    rx_alt   = 4'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  int base;
  int sbase;

  initial begin
    rst = 1'b1;
    sw = 10'd0;
    key = 4'hF;
    rx_force = 1'b0;
    rx_alt = 4'h0;

    // Reset state, then first frame in continuous mode with payload 0.
    sw = 10'b0000000001;
    repeat (3) @(negedge clk);
    #1;
    check("rst_tx", tx_sym, 4'h0);
    check("rst_ledr", ledr, 18'h0);
    check("rst_hex0", hex0, 7'b1000000);
    check("rst_hex5", hex5, 7'b1000000);
    base = dv_cnt;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("first_start", tx_sym, 4'hA);
    wait_dv(base + 1, 1000, "t1_dv");
    check("t1_latency_ok", last_wait <= 20, 1);
    check("t1_rx_byte", ledr[7:0], 8'h00);
    check("t1_rx_flag", ledr[17], 1'b1);
    check("t1_count", ledr[15:8], 8'd1);
    check("t1_hex1", hex1, 7'b1000000);
    check("t1_hex0", hex0, 7'b1000000);

    // Continuous 0x3C: value, display, and frame period.
    do_reset({1'b0, 8'h3C, 1'b1});
    base = dv_cnt;
    wait_dv(base + 1, 100, "t2_dv1");
    check("t2_rx_byte", ledr[7:0], 8'h3C);
    check("t2_hex1", hex1, 7'b0110000);
    check("t2_hex0", hex0, 7'b1000110);
    check("t2_hex5", hex5, 7'b0110000);
    check("t2_hex4", hex4, 7'b1000110);
    check("t2_count1", ledr[15:8], 8'd1);
    wait_dv(base + 2, 100, "t2_dv2");
    check("t2_period", last_wait, 32);
    check("t2_count2", ledr[15:8], 8'd2);

    // Checksum injection: never valid, sticky error.
    do_reset({1'b1, 8'h5A, 1'b1});
    base = dv_cnt;
    repeat (200) @(posedge clk);
    #1;
    check("t3_no_dv", dv_cnt - base, 0);
    check("t3_err", ledr[16], 1'b1);
    check("t3_rx_byte", ledr[7:0], 8'h00);
    check("t3_rx_flag", ledr[17], 1'b0);

    // Single-shot send of 0xF0.
    do_reset({1'b0, 8'hF0, 1'b0});
    base = dv_cnt;
    sbase = start_cnt;
    repeat (50) @(posedge clk);
    #1;
    check("t4_idle_no_start", start_cnt - sbase, 0);
    @(negedge clk);
    key[1] = 1'b0;
    repeat (5) @(negedge clk);
    key[1] = 1'b1;
    repeat (150) @(posedge clk);
    #1;
    check("t4_starts", start_cnt - sbase, 1);
    check("t4_dv_pulses", dv_cnt - base, 1);
    check("t4_count", ledr[15:8], 8'd1);
    check("t4_rx_byte", ledr[7:0], 8'hF0);
    check("t4_hex5", hex5, 7'b0001110);
    check("t4_hex4", hex4, 7'b1000000);

    // Reset in the middle of the second frame (HI symbol), then recovery.
    do_reset({1'b0, 8'h3C, 1'b1});
    repeat (40) @(posedge clk);
    #1;
    check("t5_mid_tx", tx_sym, 4'h3);
    check("t5_mid_count", ledr[15:8], 8'd1);
    #2 rst = 1'b1;
    #1;
    check("t5_async_tx", tx_sym, 4'h0);
    check("t5_async_ledr", ledr, 18'h0);
    check("t5_async_hex1", hex1, 7'b1000000);
    @(negedge clk);
    rst = 1'b0;
    base = dv_cnt;
    wait_dv(base + 1, 100, "t5_resume");
    check("t5_resume_byte", ledr[7:0], 8'h3C);
    check("t5_resume_count", ledr[15:8], 8'd1);

    // RX line drops to 0 after the HI symbol: A,3,0,0 -> checksum mismatch.
    do_reset(10'b0);
    base = dv_cnt;
    rx_force = 1'b1;
    rx_alt = 4'h0;
    repeat (4) @(negedge clk);
    rx_alt = 4'hA;
    repeat (4) @(negedge clk);
    rx_alt = 4'h3;
    repeat (4) @(negedge clk);
    rx_alt = 4'h0;
    repeat (30) @(negedge clk);
    #1;
    check("t6_early_err", ledr[16], 1'b1);
    check("t6_early_no_dv", dv_cnt - base, 0);
    rx_force = 1'b0;

    // 256 good frames of 0x81: count wraps, received flag stays set.
    do_reset({1'b0, 8'h81, 1'b1});
    base = dv_cnt;
    wait_dv(base + 255, 255 * 32 + 100, "t7_255");
    check("t7_count_255", ledr[15:8], 8'hFF);
    wait_dv(base + 256, 100, "t7_256");
    check("t7_count_wrap", ledr[15:8], 8'h00);
    check("t7_rx_flag", ledr[17], 1'b1);
    check("t7_rx_byte", ledr[7:0], 8'h81);
    check("t7_hex1", hex1, 7'b0000000);
    check("t7_hex0", hex0, 7'b1111001);

    check("dv_pulse_width", dv_long, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
